// File: rtl/hash_table_pkg.sv
// Shared encodings for the hash table command/response path.
package hash_table_pkg;
    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_READ   = 2'b01,
        OP_WRITE  = 2'b10,
        OP_DELETE = 2'b11
    } op_e;

    localparam int RSP_W  = 32;
    localparam int ST_LSB = 28;
    localparam int ST_MSB = 31;

    function automatic int cmd_width(input int key_w, input int data_w);
        return 2 + key_w + data_w;
    endfunction
endpackage

// File: rtl/hash_table_arbiter_tag_fifo.sv
// In-order requester-id queue: one tag per command in flight to the table.
module tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;

    // Storage carries no reset; only pointers/occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

// File: rtl/hash_table_arbiter.sv
// Round-robin arbiter of NUM_REQ requesters onto one hash table port,
// with in-order response routing by a tag FIFO.
module hash_table_arbiter
    import hash_table_pkg::*;
#(
    parameter int KEY_WIDTH       = 15,
    parameter int DATA_WIDTH      = 15,
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [NUM_REQ-1:0]                                  req_valid_i,
    output logic [NUM_REQ-1:0]                                  req_ready_o,
    input  logic [NUM_REQ*cmd_width(KEY_WIDTH,DATA_WIDTH)-1:0]  req_cmd_i,
    output logic                                                tbl_valid_o,
    input  logic                                                tbl_ready_i,
    output logic [cmd_width(KEY_WIDTH,DATA_WIDTH)-1:0]          tbl_cmd_o,
    input  logic                                                tbl_rsp_valid_i,
    output logic                                                tbl_rsp_ready_o,
    input  logic [RSP_W-1:0]                                    tbl_rsp_data_i,
    output logic [NUM_REQ-1:0]                                  rsp_valid_o,
    input  logic [NUM_REQ-1:0]                                  rsp_ready_i,
    output logic [RSP_W-1:0]                                    rsp_data_o,
    output logic                                                error_o
);
    localparam int CMD_W = cmd_width(KEY_WIDTH, DATA_WIDTH);
    localparam int ID_W  = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][CMD_W-1:0] cmds;
    logic [CMD_W-1:0]              stage_cmd;
    logic                          stage_vld;
    logic [ID_W-1:0]               last_grant, gnt_idx, head_id;
    logic                          gnt, can_arb, fifo_full, fifo_empty, pop;
    logic                          error;
    int                            idx;

    assign cmds    = req_cmd_i;
    assign can_arb = reset && (!stage_vld || tbl_ready_i) && !fifo_full;

    // Scan from last_grant+1 so the most recent winner has lowest priority.
    always_comb begin
        gnt         = 1'b0;
        gnt_idx     = '0;
        idx         = 0;
        req_ready_o = '0;
        if (can_arb) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(last_grant) + 1 + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!gnt && req_valid_i[idx]) begin
                    gnt     = 1'b1;
                    gnt_idx = ID_W'(idx);
                end
            end
        end
        if (gnt) req_ready_o[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_vld  <= 1'b0;
            stage_cmd  <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            error      <= 1'b0;
        end else begin
            if (gnt) begin
                stage_vld  <= 1'b1;
                stage_cmd  <= cmds[gnt_idx];
                last_grant <= gnt_idx;
            end else if (tbl_ready_i) begin
                stage_vld  <= 1'b0;
            end
            if (tbl_rsp_valid_i && fifo_empty) error <= 1'b1;
        end
    end

    // With no owner on record, a response is swallowed so the table never stalls.
    always_comb begin
        rsp_valid_o     = '0;
        tbl_rsp_ready_o = 1'b0;
        pop             = 1'b0;
        if (reset) begin
            if (fifo_empty) begin
                tbl_rsp_ready_o = 1'b1;
            end else begin
                rsp_valid_o[head_id] = tbl_rsp_valid_i;
                tbl_rsp_ready_o      = rsp_ready_i[head_id];
                pop                  = tbl_rsp_valid_i && rsp_ready_i[head_id];
            end
        end
    end

    tag_fifo #(.W(ID_W), .DEPTH(MAX_OUTSTANDING)) u_tags (
        .clk       (clk),
        .reset     (reset),
        .push      (gnt),
        .push_data (gnt_idx),
        .pop       (pop),
        .pop_data  (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tbl_valid_o = stage_vld;
    assign tbl_cmd_o   = stage_cmd;
    assign rsp_data_o  = tbl_rsp_data_i;
    assign error_o     = error;
endmodule

// File: tb/tb_hash_table_arbiter.sv
// Scoreboard bench for hash_table_arbiter: directed stimulus pushes expectations,
// negedge monitors pop and compare grants, table commands and routed responses.
module tb_hash_table_arbiter;
    import hash_table_pkg::*;

    logic             clk, reset;
    logic [3:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0][31:0] cmds;
    logic             tbl_valid, tbl_ready, tbl_rsp_valid, tbl_rsp_ready, error;
    logic [31:0]      tbl_cmd, tbl_rsp_data, rsp_data;

    int checks = 0;
    int failures = 0;
    int          exp_gnt[$];
    logic [31:0] exp_tbl[$];
    logic [35:0] exp_rsp[$];

    hash_table_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(cmds),
        .tbl_valid_o(tbl_valid), .tbl_ready_i(tbl_ready), .tbl_cmd_o(tbl_cmd),
        .tbl_rsp_valid_i(tbl_rsp_valid), .tbl_rsp_ready_o(tbl_rsp_ready),
        .tbl_rsp_data_i(tbl_rsp_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .error_o(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input op_e op, input logic [14:0] k, input logic [14:0] d);
        return {op, k, d};
    endfunction

    function automatic logic [3:0] oh(input int id);
        logic [3:0] v;
        v = 4'b0001 << id;
        return v;
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (reset) begin
            if (req_ready != 4'b0) begin
                if (exp_gnt.size() == 0) chk("grant_unexpected", 36'(req_ready), 36'h0);
                else chk("grant", 36'(req_ready), 36'(oh(exp_gnt.pop_front())));
            end
            if (tbl_valid && tbl_ready) begin
                if (exp_tbl.size() == 0) chk("tbl_unexpected", 36'(tbl_cmd), 36'h0);
                else chk("tbl_cmd", 36'(tbl_cmd), 36'(exp_tbl.pop_front()));
            end
            if ((rsp_valid & rsp_ready) != 4'b0) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", {rsp_valid, rsp_data}, 36'h0);
                else chk("rsp_route", {rsp_valid, rsp_data}, exp_rsp.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Called one step after a rising edge; returns one step after the pop edge.
    task automatic send_rsp(input logic [31:0] d, input int id);
        int n;
        n = 0;
        exp_rsp.push_back({oh(id), d});
        tbl_rsp_valid = 1'b1;
        tbl_rsp_data  = d;
        @(negedge clk);
        while (!tbl_rsp_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("rsp_timeout", 36'(n), 36'h0);
        @(posedge clk); #1;
        tbl_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; req_valid = '0; tbl_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req_valid = 4'b0; rsp_ready = 4'hF; tbl_ready = 1'b1;
        tbl_rsp_valid = 1'b1; tbl_rsp_data = 32'h0;
        for (int r = 0; r < 4; r++) cmds[r] = mk(OP_READ, 15'h0100 + 15'(r), 15'h0A00 + 15'(r));
        #3;
        chk("rst_tbl_valid", 36'(tbl_valid), 36'h0);
        chk("rst_tbl_cmd", 36'(tbl_cmd), 36'h0);
        chk("rst_tbl_rsp_ready", 36'(tbl_rsp_ready), 36'h0);
        chk("rst_error", 36'(error), 36'h0);
        tbl_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // All four requesters: 0,1,2,3,0 on consecutive cycles
        @(posedge clk); #1;
        foreach (exp_gnt[i]) ;
        for (int k = 0; k < 5; k++) begin
            exp_gnt.push_back(k % 4);
            exp_tbl.push_back(cmds[k % 4]);
        end
        req_valid = 4'hF;
        repeat (5) @(posedge clk);
        #1 req_valid = 4'h0;
        for (int k = 0; k < 5; k++) send_rsp(32'h0000_0100 + 32'(k), k % 4);

        // Table back-pressure holds the staged command
        do_reset();
        tbl_ready = 1'b0;
        cmds[1] = mk(OP_WRITE, 15'h0012, 15'h0055);
        cmds[2] = mk(OP_READ, 15'h0022, 15'h0000);
        exp_gnt.push_back(1);
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 36'(tbl_valid), 36'h1);
            chk("stall_cmd", 36'(tbl_cmd), 36'(cmds[1]));
            chk("stall_ready", 36'(req_ready), 36'h0);
        end
        @(posedge clk); #1;
        exp_tbl.push_back(cmds[1]);
        exp_gnt.push_back(2);
        exp_tbl.push_back(cmds[2]);
        tbl_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0;
        send_rsp(32'h1000_0001, 1);
        send_rsp(32'h1000_0002, 2);

        // Tag FIFO full: 9th command waits for a pop, not on the pop cycle
        do_reset();
        cmds[0] = mk(OP_DELETE, 15'h7FFF, 15'h7FFF);
        for (int k = 0; k < 9; k++) begin
            exp_gnt.push_back(0);
            exp_tbl.push_back(cmds[0]);
        end
        req_valid = 4'b0001;
        repeat (8) @(posedge clk);
        @(negedge clk) chk("full_block_a", 36'(req_ready), 36'h0);
        @(negedge clk) chk("full_block_b", 36'(req_ready), 36'h0);
        @(posedge clk); #1;
        exp_rsp.push_back({4'b0001, 32'h0000_0001});
        tbl_rsp_valid = 1'b1; tbl_rsp_data = 32'h0000_0001;
        @(negedge clk);
        chk("full_pop_block", 36'(req_ready), 36'h0);
        chk("full_rsp_ready", 36'(tbl_rsp_ready), 36'h1);
        @(posedge clk); #1;
        tbl_rsp_valid = 1'b0;
        @(negedge clk) chk("regrant", 36'(req_ready), 36'h1);
        @(posedge clk); #1;
        req_valid = 4'b0;
        for (int k = 0; k < 8; k++) send_rsp(32'h2000_0000 + 32'(k), 0);

        // Routing: grants 2 then 0, responses follow that order
        do_reset();
        cmds[0] = mk(OP_READ, 15'h0100, 15'h0A00);
        exp_gnt.push_back(2); exp_tbl.push_back(cmds[2]);
        req_valid = 4'b0100;
        @(posedge clk); #1;
        exp_gnt.push_back(0); exp_tbl.push_back(cmds[0]);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = 4'b0;
        rsp_ready = 4'b1011;
        tbl_rsp_valid = 1'b1; tbl_rsp_data = 32'h1000_0005;
        @(negedge clk);
        chk("bp_tbl_rsp_ready", 36'(tbl_rsp_ready), 36'h0);
        chk("bp_rsp_valid", {rsp_valid, rsp_data}, {4'b0100, 32'h1000_0005});
        @(posedge clk); #1;
        exp_rsp.push_back({4'b0100, 32'h1000_0005});
        rsp_ready = 4'hF;
        @(posedge clk); #1;
        send_rsp(32'h8000_0000, 0);

        // Stray response with nothing outstanding
        chk("err_before", 36'(error), 36'h0);
        tbl_rsp_valid = 1'b1; tbl_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stray_rsp_ready", 36'(tbl_rsp_ready), 36'h1);
        chk("stray_rsp_valid", 36'(rsp_valid), 36'h0);
        @(posedge clk); #1;
        tbl_rsp_valid = 1'b0;
        chk("err_set", 36'(error), 36'h1);
        repeat (3) @(posedge clk);
        #1 chk("err_sticky", 36'(error), 36'h1);

        // Reset with three commands outstanding (last grant was 0)
        exp_gnt.push_back(1); exp_gnt.push_back(2); exp_gnt.push_back(3);
        exp_tbl.push_back(cmds[1]); exp_tbl.push_back(cmds[2]);
        req_valid = 4'b1110;
        repeat (3) @(posedge clk);
        #1 tbl_ready = 1'b0;
        #1 reset = 1'b0; tbl_rsp_valid = 1'b1; tbl_rsp_data = 32'h4000_0000;
        #1;
        chk("mid_rst_tbl_valid", 36'(tbl_valid), 36'h0);
        chk("mid_rst_tbl_cmd", 36'(tbl_cmd), 36'h0);
        chk("mid_rst_req_ready", 36'(req_ready), 36'h0);
        chk("mid_rst_rsp_valid", 36'(rsp_valid), 36'h0);
        chk("mid_rst_tbl_rsp_ready", 36'(tbl_rsp_ready), 36'h0);
        chk("mid_rst_error", 36'(error), 36'h0);
        @(posedge clk); #1;
        tbl_rsp_valid = 1'b0;
        @(posedge clk); #1;
        exp_gnt.push_back(0); exp_tbl.push_back(cmds[0]);
        reset = 1'b1; tbl_ready = 1'b1; req_valid = 4'hF;
        @(posedge clk); #1;
        req_valid = 4'b0;
        send_rsp(32'h0000_0077, 0);
        repeat (2) @(posedge clk);
        #1 chk("queues_empty", 36'(exp_gnt.size() + exp_tbl.size() + exp_rsp.size()), 36'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
